// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle datapath: the multiply/divide unit
// state encoding, its operation select codes and the default datapath width.
// Optional feature macro used by the units that import this package:
//   MULT_DIV_SIGNED_EN - two's complement mult/div instead of unsigned.
// ----------------------------------------------------------------------------
package cpu_pkg;

    // Default operand/result width of the datapath.
    localparam int MDU_WIDTH_DEFAULT = 32;

    // Operation select driven by the control unit.
    localparam logic MDU_OP_MULT = 1'b0;
    localparam logic MDU_OP_DIV  = 1'b1;

    // Multiply/divide unit sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_sign_fix.sv
// ----------------------------------------------------------------------------
// mdu_sign_fix
// Combinational sign handling for mult_div_unit.
//   Entry side : a, b            -> a_abs, b_abs (magnitudes), neg_res (a^b
//                                   sign), neg_rem (sign of a).
//   Exit side  : op, neg_res_q, neg_rem_q, raw_hi, raw_lo (unsigned result)
//                                -> fix_hi, fix_lo (sign-corrected result).
// With MULT_DIV_SIGNED_EN undefined all of this collapses to wires: the
// magnitudes are the operands, the sign flags are zero and the result passes
// through untouched.
// ----------------------------------------------------------------------------
module mdu_sign_fix
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] a_abs,
    output logic [WIDTH-1:0] b_abs,
    output logic             neg_res,
    output logic             neg_rem,
    input  logic             op,
    input  logic             neg_res_q,
    input  logic             neg_rem_q,
    input  logic [WIDTH-1:0] raw_hi,
    input  logic [WIDTH-1:0] raw_lo,
    output logic [WIDTH-1:0] fix_hi,
    output logic [WIDTH-1:0] fix_lo
);

`ifdef MULT_DIV_SIGNED_EN

    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    logic [2*WIDTH-1:0] prod_neg_s;

    // Operand magnitudes and result signs captured on entry.
    always_comb begin
        if (a[WIDTH-1]) begin
            a_abs = ~a + ONE_W;
        end else begin
            a_abs = a;
        end
        if (b[WIDTH-1]) begin
            b_abs = ~b + ONE_W;
        end else begin
            b_abs = b;
        end
        neg_res = a[WIDTH-1] ^ b[WIDTH-1];
        neg_rem = a[WIDTH-1];
    end

    // The product is negated as one 2*WIDTH value so the borrow crosses words.
    assign prod_neg_s = ~{raw_hi, raw_lo} + ONE_2W;

    // Sign correction applied to the finished result.
    always_comb begin
        fix_hi = raw_hi;
        fix_lo = raw_lo;
        if (op == MDU_OP_MULT) begin
            if (neg_res_q) begin
                fix_hi = prod_neg_s[2*WIDTH-1:WIDTH];
                fix_lo = prod_neg_s[WIDTH-1:0];
            end else begin
                fix_hi = raw_hi;
                fix_lo = raw_lo;
            end
        end else begin
            // MIN_INT / -1 wraps back to MIN_INT here without any flag.
            if (neg_res_q) begin
                fix_lo = ~raw_lo + ONE_W;
            end else begin
                fix_lo = raw_lo;
            end
            if (neg_rem_q) begin
                fix_hi = ~raw_hi + ONE_W;
            end else begin
                fix_hi = raw_hi;
            end
        end
    end

`else

    logic unused_sign_s;

    assign a_abs         = a;
    assign b_abs         = b;
    assign neg_res       = 1'b0;
    assign neg_rem       = 1'b0;
    assign fix_hi        = raw_hi;
    assign fix_lo        = raw_lo;
    assign unused_sign_s = ^{op, neg_res_q, neg_rem_q};

`endif

endmodule

// File: rtl/mult_div_unit.sv
// ----------------------------------------------------------------------------
// mult_div_unit
// Iterative multiply/divide unit. A start pulse in IDLE latches the operand
// magnitudes, then WIDTH iterations of shift-add multiply or restoring divide
// run one per cycle, followed by one FINISH cycle that sign-corrects, writes
// HI/LO and pulses done.
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   start, op       request pulse (IDLE only); 0 = multiply, 1 = divide
//   a, b            operands (multiplicand/dividend, multiplier/divisor)
//   busy            high from the start edge through the FINISH cycle
//   done            one-cycle pulse when hi/lo are valid
//   hi, lo          product high/low word, or remainder/quotient
//   div_zero        last accepted divide had b == 0 (hi/lo left unchanged)
// Macro: MULT_DIV_SIGNED_EN selects two's complement operation (mult/div);
// without it the unit is unsigned (multu/divu). Timing is identical.
// ----------------------------------------------------------------------------
module mult_div_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // acc: multiply accumulator (with carry bit) or divide partial remainder.
    logic [WIDTH:0]   acc_q, acc_d;
    // lo_work: multiplier being shifted out, or dividend/quotient.
    logic [WIDTH-1:0] lo_work_q, lo_work_d;
    // opnd: multiplicand magnitude or divisor magnitude.
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dz_q, dz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] a_abs_s, b_abs_s;
    logic             neg_res_s, neg_rem_s;
    logic [WIDTH-1:0] fix_hi_s, fix_lo_s;
    logic [WIDTH-1:0] addend_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_trial_s;

    mdu_sign_fix #(
        .WIDTH (WIDTH)
    ) u_sign_fix (
        .a         (a),
        .b         (b),
        .a_abs     (a_abs_s),
        .b_abs     (b_abs_s),
        .neg_res   (neg_res_s),
        .neg_rem   (neg_rem_s),
        .op        (op_q),
        .neg_res_q (neg_res_q),
        .neg_rem_q (neg_rem_q),
        .raw_hi    (acc_q[WIDTH-1:0]),
        .raw_lo    (lo_work_q),
        .fix_hi    (fix_hi_s),
        .fix_lo    (fix_lo_s)
    );

    // Datapath for one multiply or divide iteration.
    always_comb begin
        if (lo_work_q[0]) begin
            addend_s = opnd_q;
        end else begin
            addend_s = '0;
        end
        mul_sum_s   = acc_q + {1'b0, addend_s};
        div_shift_s = {acc_q[WIDTH-1:0], lo_work_q[WIDTH-1]};
        div_trial_s = div_shift_s - {1'b0, opnd_q};
    end

    // Next-state and next-register logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        lo_work_d  = lo_work_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dz_d       = dz_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d       = op;
                    neg_res_d  = neg_res_s;
                    neg_rem_d  = neg_rem_s;
                    acc_d      = '0;
                    cnt_d      = '0;
                    div_zero_d = 1'b0;
                    busy_d     = 1'b1;
                    if (op == MDU_OP_DIV) begin
                        lo_work_d = a_abs_s;
                        opnd_d    = b_abs_s;
                    end else begin
                        lo_work_d = b_abs_s;
                        opnd_d    = a_abs_s;
                    end
                    // A zero divisor skips the iterations entirely.
                    if ((op == MDU_OP_DIV) && (b == '0)) begin
                        dz_d    = 1'b1;
                        state_d = FINISH;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = CALC;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            CALC: begin
                if (op_q == MDU_OP_MULT) begin
                    // Shift {acc, mplier} right, the add's carry re-enters acc.
                    acc_d     = {1'b0, mul_sum_s[WIDTH:1]};
                    lo_work_d = {mul_sum_s[0], lo_work_q[WIDTH-1:1]};
                end else begin
                    // Restoring step: keep the shifted remainder if the trial
                    // subtraction went negative, otherwise take the difference.
                    if (div_trial_s[WIDTH]) begin
                        acc_d     = div_shift_s;
                        lo_work_d = {lo_work_q[WIDTH-2:0], 1'b0};
                    end else begin
                        acc_d     = div_trial_s;
                        lo_work_d = {lo_work_q[WIDTH-2:0], 1'b1};
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = FINISH;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                    state_d = CALC;
                end
            end

            FINISH: begin
                if (dz_q) begin
                    hi_d = hi_q;
                    lo_d = lo_q;
                end else begin
                    hi_d = fix_hi_s;
                    lo_d = fix_lo_s;
                end
                div_zero_d = dz_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            lo_work_q  <= '0;
            opnd_q     <= '0;
            op_q       <= MDU_OP_MULT;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            lo_work_q  <= lo_work_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = div_zero_q;

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the multicycle datapath. It sits directly downstream of the control unit. The control unit pulses `start` with an operation select. This block then runs a WIDTH-cycle shift-add multiply or a restoring divide on the A/B register values, writes the HI/LO registers and returns a one-cycle `done` pulse. The control unit holds in its wait state until that pulse arrives.

## Interface
- WIDTH, 32, operand and result width; must be ≥ 2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  request pulse; accepted only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- a  in  WIDTH  operand A (multiplicand / dividend).
- b  in  WIDTH  operand B (multiplier / divisor).
- busy  out  1  high in CALC and FINISH.
- done  out  1  one-cycle pulse when HI/LO become valid.
- hi  out  WIDTH  product high word / remainder.
- lo  out  WIDTH  product low word / quotient.
- div_zero  out  1  last accepted divide had b == 0.

## Operation
- Reset values: busy=0, done=0, hi=0, lo=0, div_zero=0; state IDLE; iteration counter 0.
- States: IDLE, CALC, FINISH.
- IDLE, start=1:
  - Latch |a|, |b|, op and the result signs.
  - Clear div_zero.
  - Go to CALC, counter=0.
- IDLE, start=1, op=1, b==0:
  - Set div_zero=1.
  - Go straight to FINISH; hi/lo are not written.
- start in CALC or FINISH: ignored; not queued.
- CALC, one iteration per cycle:
  - Multiply: {acc,mplier} shifts right; acc += mcand when mplier[0]=1; carry-out kept in a WIDTH+1-bit accumulator.
  - Divide: restoring. Shift {rem,quot} left, trial-subtract the divisor, restore if the result is negative, set quotient bit.
  - After iteration WIDTH-1: go to FINISH.
- FINISH, one cycle:
  - Apply sign correction.
  - Write hi/lo, except on div_zero.
  - done=1, then return to IDLE.
- Sign rules:
  - Product sign = a^b sign; the 2·WIDTH product is negated as one value.
  - Quotient sign = a^b; remainder sign = a.
- Overflow: MIN_INT / -1 yields lo=MIN_INT, hi=0 (natural wrap); no flag.
- Reset mid-operation: the next edge returns to IDLE with all outputs at reset values; the partial result is discarded.
- a/b may change after the start edge; only the latched copies are used.

## Timing
- Start edge = E0.
- busy=1 from E0 through the FINISH cycle.
- Iterations at edges E1..E_WIDTH.
- FINISH cycle follows E_WIDTH; hi/lo/done update at E_WIDTH+1.
- done is high for exactly one cycle: WIDTH+1 cycles after the start edge (33 for WIDTH=32).
- busy falls at the same edge done rises.
- Divide-by-zero: done and div_zero at E1; busy high for one cycle.
- Back-to-back: start can be accepted in the cycle done is high; that edge is E0 of the next operation.

## Configuration
- MULT_DIV_SIGNED_EN defined: operands are two's complement; absolute-value and sign-correction logic is compiled in (MIPS mult/div).
- Not defined: operands and results are unsigned (multu/divu semantics); no sign logic. Timing is identical.

## Structure
- Shared package (cpu_pkg):
  - mdu_state_t enum {IDLE, CALC, FINISH}.
  - MDU_OP_MULT=1'b0, MDU_OP_DIV=1'b1.
  - Default WIDTH constant.
- One sub-module, mdu_sign_fix (combinational):
  - Absolute value of the operands on entry.
  - Conditional negation of the product/quotient/remainder in FINISH.
  - Compiled out entirely when MULT_DIV_SIGNED_EN is absent.
- Counter width: $clog2(WIDTH).

## Test plan
- mult a=7, b=6 -> done at E33; hi=0, lo=42; busy high E0..E32.
- Signed mult a=-3, b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. With the macro off: a=0xFFFFFFFF, b=2 -> hi=1, lo=0xFFFFFFFE.
- div a=100, b=7 -> lo=14, hi=2. Signed a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- div b=0 with hi/lo preloaded -> done and div_zero at E1; hi/lo unchanged. The next accepted start clears div_zero.
- start pulsed at E5 during a multiply -> ignored; the original result arrives at E33. A new start in the done cycle is accepted.
- reset asserted at E10 of a divide -> busy, done, hi, lo, div_zero = 0 after the next edge. A subsequent start completes normally.
